// File: rtl/cnn2_act_fetch.sv
// cnn2_act_fetch: read-side engine for the layer-1 -> layer-2 activation buffer.
//
// Waits until layer 1 has committed enough samples, walks the 4-channel buffer in
// 1-D sliding-window order (KLEN taps per output position, STRIDE between positions),
// absorbs the buffer's 1-cycle read latency and streams scaled activations to layer 2.
//
// Ports:
//   clk                 single clock, rising edge
//   global_rst          asynchronous active-low reset
//   start               begins one full pass (ignored unless idle)
//   wr_count            samples committed by layer 1 (monotonic during a pass)
//   rd_en / rd_addr     buffer read strobe / address
//   rd_data0..3         buffer read data, valid one cycle after rd_en
//   act0..3             activation = {rd_dataN, 9'b0}
//   act_valid/act_ready beat handshake; act_tap / act_pos tag each beat with (k, p)
//   busy                high from start acceptance until done
//   done                one-cycle pulse after the last beat is accepted
module cnn2_act_fetch #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAP_LEN = 2500,
  parameter int unsigned KLEN    = 3,
  parameter int unsigned STRIDE  = 1
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] rd_data3,
  output logic [DATA_W+8:0] act0,
  output logic [DATA_W+8:0] act1,
  output logic [DATA_W+8:0] act2,
  output logic [DATA_W+8:0] act3,
  output logic              act_valid,
  input  logic              act_ready,
  output logic [3:0]        act_tap,
  output logic [ADDR_W-1:0] act_pos,
  output logic              busy,
  output logic              done
);

  localparam int OUT_LEN = (int'(MAP_LEN) - int'(KLEN)) / int'(STRIDE) + 1;

  if (STRIDE < 1 || KLEN < 1 || KLEN > 16 || MAP_LEN < KLEN || OUT_LEN < 1 ||
      MAP_LEN > (1 << ADDR_W)) begin : g_bad_cfg
    $error("cnn2_act_fetch: illegal MAP_LEN/KLEN/STRIDE/ADDR_W combination");
  end

  localparam logic [ADDR_W-1:0] StrideA = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LastP   = ADDR_W'(OUT_LEN - 1);
  localparam logic [3:0]        LastK   = 4'(KLEN - 1);
  // FIFO entry: {d3, d2, d1, d0, k, p}
  localparam int unsigned EntW = 4 * DATA_W + 4 + ADDR_W;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Window walk: a_q = base_q + k_q is kept incrementally, base_q = p_q * STRIDE.
  logic [ADDR_W-1:0] p_q, p_d;
  logic [3:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  // One read in flight at most per cycle; its tags ride along until the data returns.
  logic              pend_q;
  logic [3:0]        pend_k_q;
  logic [ADDR_W-1:0] pend_p_q;

  logic [EntW-1:0]   mem_q [2];
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              rd_ptr_q, wr_ptr_q;

  logic              issue, last_issue;
  logic              pop, bypass, push_store, pop_store;
  logic [EntW-1:0]   ret_entry, head;

  // Credit counts stored entries plus the read whose data is on rd_data now.
  assign issue      = (state_q == StFetch) && (a_q < wr_count) &&
                      ((fifo_cnt_q + {1'b0, pend_q}) < 2'd2);
  assign last_issue = issue && (p_q == LastP) && (k_q == LastK);

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (last_issue) state_d = StDrain;
      StDrain: if ((fifo_cnt_q == 2'd0) && !pend_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_en   = issue;
    rd_addr = issue ? a_q : rd_addr_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Address walk
  always_comb begin
    p_d       = p_q;
    k_d       = k_q;
    base_d    = base_q;
    a_d       = a_q;
    rd_addr_d = rd_addr_q;
    if ((state_q == StIdle) && start) begin
      p_d    = '0;
      k_d    = '0;
      base_d = '0;
      a_d    = '0;
    end else if (issue) begin
      rd_addr_d = a_q;
      if (k_q == LastK) begin
        k_d    = '0;
        p_d    = p_q + 1'b1;
        base_d = base_q + StrideA;
        a_d    = base_q + StrideA;
      end else begin
        k_d = k_q + 4'd1;
        a_d = a_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      p_q       <= '0;
      k_q       <= '0;
      base_q    <= '0;
      a_q       <= '0;
      rd_addr_q <= '0;
      pend_q    <= 1'b0;
      pend_k_q  <= '0;
      pend_p_q  <= '0;
    end else begin
      p_q       <= p_d;
      k_q       <= k_d;
      base_q    <= base_d;
      a_q       <= a_d;
      rd_addr_q <= rd_addr_d;
      pend_q    <= issue;
      if (issue) begin
        pend_k_q <= k_q;
        pend_p_q <= p_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return path / 2-entry skid FIFO. Returning data counts as a FIFO entry in the
  // cycle it arrives; when the FIFO is empty it is presented directly and only
  // stored if layer 2 does not take it.
  assign ret_entry  = {rd_data3, rd_data2, rd_data1, rd_data0, pend_k_q, pend_p_q};
  assign act_valid  = (fifo_cnt_q != 2'd0) || pend_q;
  assign pop        = act_valid && act_ready;
  assign bypass     = (fifo_cnt_q == 2'd0) && pend_q && pop;
  assign push_store = pend_q && !bypass;
  assign pop_store  = pop && !bypass;
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push_store} - {1'b0, pop_store};

  always_comb begin
    head = '0;
    if (fifo_cnt_q != 2'd0) begin
      head = mem_q[rd_ptr_q];
    end else if (pend_q) begin
      head = ret_entry;
    end
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      if (push_store) begin
        mem_q[wr_ptr_q] <= ret_entry;
      end
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_q ^ push_store;
      rd_ptr_q   <= rd_ptr_q ^ pop_store;
    end
  end

  assign act_pos = head[ADDR_W-1:0];
  assign act_tap = head[ADDR_W+3:ADDR_W];
  assign act0    = {head[ADDR_W+4+0*DATA_W +: DATA_W], 9'b0};
  assign act1    = {head[ADDR_W+4+1*DATA_W +: DATA_W], 9'b0};
  assign act2    = {head[ADDR_W+4+2*DATA_W +: DATA_W], 9'b0};
  assign act3    = {head[ADDR_W+4+3*DATA_W +: DATA_W], 9'b0};

endmodule

// File: tb/tb_cnn2_act_fetch.sv
// Bench for cnn2_act_fetch. Two instances: a small one (MAP_LEN=8, STRIDE=2) and the
// default-size one (MAP_LEN=2500, STRIDE=1); cur selects which one is being exercised.
// Buffer word for address i, channel c is (i + 1 + 37*c) mod 256.
module tb_cnn2_act_fetch;

  logic clk = 1'b0;
  logic global_rst;

  logic [1:0]             start_v;
  logic [1:0][11:0]       wr_count_v;
  logic [1:0]             rd_en_v;
  logic [1:0][11:0]       rd_addr_v;
  logic [1:0][3:0][7:0]   rd_data_v;
  logic [1:0][3:0][16:0]  act_v;
  logic [1:0]             act_valid_v;
  logic [1:0]             act_ready_v;
  logic [1:0][3:0]        act_tap_v;
  logic [1:0][11:0]       act_pos_v;
  logic [1:0]             busy_v;
  logic [1:0]             done_v;

  for (genvar j = 0; j < 2; j++) begin : g_dut
    cnn2_act_fetch #(
      .ADDR_W (12),
      .DATA_W (8),
      .MAP_LEN((j == 0) ? 8 : 2500),
      .KLEN   (3),
      .STRIDE ((j == 0) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .global_rst(global_rst),
      .start     (start_v[j]),
      .wr_count  (wr_count_v[j]),
      .rd_en     (rd_en_v[j]),
      .rd_addr   (rd_addr_v[j]),
      .rd_data0  (rd_data_v[j][0]),
      .rd_data1  (rd_data_v[j][1]),
      .rd_data2  (rd_data_v[j][2]),
      .rd_data3  (rd_data_v[j][3]),
      .act0      (act_v[j][0]),
      .act1      (act_v[j][1]),
      .act2      (act_v[j][2]),
      .act3      (act_v[j][3]),
      .act_valid (act_valid_v[j]),
      .act_ready (act_ready_v[j]),
      .act_tap   (act_tap_v[j]),
      .act_pos   (act_pos_v[j]),
      .busy      (busy_v[j]),
      .done      (done_v[j])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [7:0] fdat(input int a, input int c);
    return 8'(a + 1 + 37 * c);
  endfunction

  // Buffer model: one-cycle read latency.
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rd_en_v[j]) begin
        for (int c = 0; c < 4; c++) rd_data_v[j][c] <= fdat(int'(rd_addr_v[j]), c);
      end
    end
  end

  // Selected instance
  int cur;
  logic              rd_en_s, act_valid_s, act_ready_s, busy_s, done_s;
  logic [11:0]       rd_addr_s, act_pos_s, wr_count_s;
  logic [3:0]        act_tap_s;
  logic [3:0][16:0]  act_s;
  assign rd_en_s     = rd_en_v[cur];
  assign rd_addr_s   = rd_addr_v[cur];
  assign wr_count_s  = wr_count_v[cur];
  assign act_s       = act_v[cur];
  assign act_valid_s = act_valid_v[cur];
  assign act_ready_s = act_ready_v[cur];
  assign act_tap_s   = act_tap_v[cur];
  assign act_pos_s   = act_pos_v[cur];
  assign busy_s      = busy_v[cur];
  assign done_s      = done_v[cur];

  function automatic logic [127:0] outs_now();
    return 128'({rd_en_s, rd_addr_s, act_s, act_valid_s, act_tap_s, act_pos_s, busy_s, done_s});
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scenario-owned settings
  bit chk_en = 0;
  bit hold_off = 0;
  int exp_total = 0;
  int stride_m = 2;
  int rdy_mode = 0;
  int t0 = 0;
  int cyc = 0;

  // Expected address of the idx-th read/beat: window p = idx/3, tap k = idx%3.
  function automatic int exp_addr(input int idx);
    return (idx / 3) * stride_m + (idx % 3);
  endfunction

  // Ready generator
  always @(posedge clk) begin
    int rel;
    logic r;
    cyc++;
    #1;
    rel = cyc - t0;
    case (rdy_mode)
      0: r = 1'b1;
      1: r = (rel >= 6 && rel < 16) ? 1'b0 : rel[0];
      default: r = 1'($urandom_range(0, 1));
    endcase
    act_ready_v = {r, r};
  end

  // Compare process (monitor-owned counters)
  int iss, acc, done_cnt, last_pos, last_rd;
  int m_p, m_k, m_a;
  bit stall_q;
  logic [127:0] prev_bits;
  int obs_addr[$];
  int obs_act0[$];
  int obs_tap[$];
  int obs_pos[$];

  always @(negedge clk) begin
    if (!chk_en) begin
      iss = 0; acc = 0; done_cnt = 0; stall_q = 0; last_pos = 0; last_rd = 0;
      obs_addr.delete(); obs_act0.delete(); obs_tap.delete(); obs_pos.delete();
    end else begin
      if (done_s) begin
        done_cnt++;
        if (!hold_off) chk("done_after_last_beat", 128'(acc), 128'(exp_total));
      end
      if (!hold_off) begin
        chk("act_valid", 128'(act_valid_s), 128'((iss - acc) > 0));
        if (stall_q) begin
          chk("hold_stable", 128'({act_s, act_tap_s, act_pos_s, act_valid_s}), prev_bits);
        end
        if (rd_en_s) begin
          chk("rd_addr", 128'(rd_addr_s), 128'(exp_addr(iss)));
          chk("rd_below_wr_count", 128'(rd_addr_s < wr_count_s), 128'(1));
          chk("rd_credit", 128'((iss + 1 - acc) <= 2), 128'(1));
          chk("rd_not_extra", 128'(iss < exp_total), 128'(1));
          last_rd = int'(rd_addr_s);
          obs_addr.push_back(int'(rd_addr_s));
          iss++;
        end
        if (act_valid_s && act_ready_s) begin
          m_p = acc / 3;
          m_k = acc % 3;
          m_a = m_p * stride_m + m_k;
          chk("beat_tap", 128'(act_tap_s), 128'(m_k));
          chk("beat_pos", 128'(act_pos_s), 128'(m_p));
          for (int c = 0; c < 4; c++) begin
            chk("beat_act", 128'(act_s[c]), 128'(int'(fdat(m_a, c)) * 512));
          end
          chk("beat_not_extra", 128'(acc < exp_total), 128'(1));
          last_pos = int'(act_pos_s);
          obs_act0.push_back(int'(act_s[0]));
          obs_tap.push_back(int'(act_tap_s));
          obs_pos.push_back(int'(act_pos_s));
          acc++;
        end
        stall_q   = act_valid_s && !act_ready_s;
        prev_bits = 128'({act_s, act_tap_s, act_pos_s, act_valid_s});
      end
    end
  end

  task automatic start_pass();
    exp_total = (cur == 0) ? 9 : 2498 * 3;
    stride_m  = (cur == 0) ? 2 : 1;
    chk_en    = 0;
    hold_off  = 0;
    @(negedge clk);
    #1 chk_en = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_v[cur] = 1'b1;
    @(posedge clk);
    #1 start_v[cur] = 1'b0;
  endtask

  task automatic finish_pass(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 128'(done_cnt), 128'(1));
    chk("beats_total", 128'(acc), 128'(exp_total));
    chk("reads_total", 128'(iss), 128'(exp_total));
    chk("busy_after_done", 128'(busy_s), 128'(0));
  endtask

  int lit_addr[9] = '{0, 1, 2, 2, 3, 4, 4, 5, 6};
  int lit_act0[9] = '{512, 1024, 1536, 1536, 2048, 2560, 2560, 3072, 3584};
  int lit_tap[9]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int lit_pos[9]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  initial begin
    logic seen;
    global_rst = 1'b0;
    start_v    = '0;
    wr_count_v = '0;
    cur        = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_now(), 128'(0));
    @(negedge clk);
    global_rst = 1'b1;

    // Basic stream
    cur = 0; wr_count_v[0] = 12'd8; rdy_mode = 0;
    start_pass();
    finish_pass(200);
    chk("basic_n_reads", 128'(obs_addr.size()), 128'(9));
    for (int i = 0; i < 9; i++) begin
      chk("basic_addr", 128'((i < obs_addr.size()) ? obs_addr[i] : -1), 128'(lit_addr[i]));
      chk("basic_act0", 128'((i < obs_act0.size()) ? obs_act0[i] : -1), 128'(lit_act0[i]));
      chk("basic_tap", 128'((i < obs_tap.size()) ? obs_tap[i] : -1), 128'(lit_tap[i]));
      chk("basic_pos", 128'((i < obs_pos.size()) ? obs_pos[i] : -1), 128'(lit_pos[i]));
    end

    // Producer throttle
    wr_count_v[0] = 12'd3;
    start_pass();
    repeat (20) @(posedge clk);
    #1;
    chk("throttle_reads", 128'(iss), 128'(4));
    chk("throttle_stalled", 128'(rd_en_s), 128'(0));
    wr_count_v[0] = 12'd8;
    @(negedge clk);
    seen = rd_en_s;
    chk("throttle_resume", 128'(seen), 128'(1));
    finish_pass(200);

    // Backpressure
    rdy_mode = 1;
    start_pass();
    finish_pass(400);

    // Start while busy
    rdy_mode = 0;
    start_pass();
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    finish_pass(200);

    // Reset mid-pass
    start_pass();
    for (int i = 0; i < 50 && acc < 4; i++) @(posedge clk);
    chk("reached_4_beats", 128'(acc >= 4), 128'(1));
    #3;
    hold_off = 1;
    global_rst = 1'b0;
    #1;
    chk("midpass_reset_outputs", outs_now(), 128'(0));
    repeat (5) @(posedge clk);
    chk("no_done_after_reset", 128'(done_cnt), 128'(0));
    @(negedge clk);
    global_rst = 1'b1;
    start_pass();
    finish_pass(200);
    chk("restart_addr0", 128'((obs_addr.size() > 0) ? obs_addr[0] : -1), 128'(0));

    // Full size, stride 1, random ready
    cur = 1; wr_count_v[1] = 12'd2500; rdy_mode = 2;
    start_pass();
    finish_pass(40000);
    chk("full_last_pos", 128'(last_pos), 128'(2497));
    chk("full_last_rd_addr", 128'(last_rd), 128'(2499));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
